// File: rtl/lsu_dmem_if_pkg.sv
// Shared encodings for the data-side load/store unit: LOADSel codes, FSM states,
// error causes, and the legality/alignment rules used when a request is accepted.
package lsu_dmem_if_pkg;

  localparam logic [3:0] LS_W  = 4'd0;
  localparam logic [3:0] LS_B  = 4'd1;
  localparam logic [3:0] LS_BU = 4'd2;
  localparam logic [3:0] LS_H  = 4'd3;
  localparam logic [3:0] LS_HU = 4'd4;
  localparam logic [3:0] LS_SB = 4'd5;
  localparam logic [3:0] LS_SH = 4'd6;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Not yet driven onto a port; kept so a cause field can be added without re-encoding.
  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_ILLEGAL  = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } err_cause_e;

  function automatic logic is_legal(input logic we, input logic [3:0] sel);
    if (we)
      return (sel == LS_W) || (sel == LS_SB) || (sel == LS_SH);
    else
      return (sel <= LS_HU);
  endfunction

  function automatic logic is_aligned(input logic [3:0] sel, input logic [1:0] off);
    case (sel)
      LS_W:               return (off == 2'b00);
      LS_H, LS_HU, LS_SH: return ~off[0];
      default:            return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering: store byte enables and data replication from the live request,
// and load extraction/extension from the latched access and the returned word.
module lsu_lane
  import lsu_dmem_if_pkg::*;
(
  input  logic        we,
  input  logic [3:0]  st_sel,
  input  logic [1:0]  st_off,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  input  logic [3:0]  ld_sel,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata_word,
  output logic [31:0] load_data
);

  logic [3:0]  byte_hit;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign byte_hit[gi] = (st_off == 2'(gi));
    end
  endgenerate

  always_comb begin
    be        = 4'b0000;
    wdata_rep = wdata;
    if (we) begin
      case (st_sel)
        LS_W:  be = 4'b1111;
        LS_SB: begin
          be        = byte_hit;
          wdata_rep = {4{wdata[7:0]}};
        end
        LS_SH: begin
          be        = st_off[1] ? 4'b1100 : 4'b0011;
          wdata_rep = {2{wdata[15:0]}};
        end
        default: be = 4'b0000;
      endcase
    end
  end

  always_comb begin
    case (ld_off)
      2'd0:    ld_byte = rdata_word[7:0];
      2'd1:    ld_byte = rdata_word[15:8];
      2'd2:    ld_byte = rdata_word[23:16];
      default: ld_byte = rdata_word[31:24];
    endcase
    ld_half = ld_off[1] ? rdata_word[31:16] : rdata_word[15:0];
  end

  always_comb begin
    case (ld_sel)
      LS_W:    load_data = rdata_word;
      LS_B:    load_data = {{24{ld_byte[7]}}, ld_byte};
      LS_BU:   load_data = {24'h0, ld_byte};
      LS_H:    load_data = {{16{ld_half[15]}}, ld_half};
      LS_HU:   load_data = {16'h0, ld_half};
      default: load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_dmem_if.sv
// Load/store responder: stalls the core while a single handshaked data-memory access
// runs, then retires it with a one-cycle done pulse carrying the load result or an error.
module lsu_dmem_if
  import lsu_dmem_if_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int TW      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [3:0]  sel,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  logic [1:0]    state_reg, state_next;
  logic [TW-1:0] timer_reg;
  logic [3:0]    sel_reg;
  logic [1:0]    off_reg;
  logic          err_reg;
  logic [31:0]   rdata_reg;

  logic          access_ok;
  logic          start_bus, finish_ok, finish_err;
  logic [3:0]    lane_be;
  logic [31:0]   lane_wdata;
  logic [31:0]   load_data;

  lsu_lane u_lane (
    .we         (we),
    .st_sel     (sel),
    .st_off     (addr[1:0]),
    .wdata      (wdata),
    .be         (lane_be),
    .wdata_rep  (lane_wdata),
    .ld_sel     (sel_reg),
    .ld_off     (off_reg),
    .rdata_word (mem_rdata),
    .load_data  (load_data)
  );

  assign access_ok = is_legal(we, sel) && is_aligned(sel, addr[1:0]);

  always_comb begin
    state_next = state_reg;
    start_bus  = 1'b0;
    finish_ok  = 1'b0;
    finish_err = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (req) begin
          if (access_ok) begin
            state_next = ST_BUS;
            start_bus  = 1'b1;
          end else begin
            state_next = ST_DONE;
            finish_err = 1'b1;
          end
        end
      end
      ST_BUS: begin
        // An ack in the final allowed cycle still completes cleanly.
        if (mem_ack) begin
          state_next = ST_DONE;
          finish_ok  = 1'b1;
        end else if (timer_reg == TW'(TIMEOUT - 1)) begin
          state_next = ST_DONE;
          finish_err = 1'b1;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      timer_reg <= '0;
      sel_reg   <= 4'h0;
      off_reg   <= 2'b00;
      err_reg   <= 1'b0;
      rdata_reg <= 32'h0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'b0000;
      mem_addr  <= 30'h0;
      mem_wdata <= 32'h0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_BUS)
        timer_reg <= timer_reg + TW'(1);
      if (state_reg == ST_DONE)
        err_reg <= 1'b0;
      if (start_bus) begin
        timer_reg <= '0;
        sel_reg   <= sel;
        off_reg   <= addr[1:0];
        mem_req   <= 1'b1;
        mem_we    <= we;
        mem_be    <= lane_be;
        mem_addr  <= addr[31:2];
        mem_wdata <= lane_wdata;
      end
      if (finish_ok) begin
        mem_req   <= 1'b0;
        err_reg   <= 1'b0;
        rdata_reg <= mem_we ? 32'h0 : load_data;
      end
      if (finish_err) begin
        mem_req   <= 1'b0;
        err_reg   <= 1'b1;
        rdata_reg <= 32'h0;
      end
    end
  end

  // Gated by rst so an aborted access releases the pipeline at once.
  assign stall = ~rst & (((state_reg == ST_IDLE) & req) | (state_reg == ST_BUS));
  assign done  = (state_reg == ST_DONE);
  assign err   = err_reg;
  assign rdata = rdata_reg;

endmodule

// File: tb/tb_lsu_dmem_if.sv
// Directed and random load/store transactions against a reference model built from
// access size and byte offset arithmetic; memory responder with programmable ack delay.
module tb_lsu_dmem_if;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we;
  logic [3:0]  sel;
  logic [31:0] addr, wdata;
  logic        stall, done, err;
  logic [31:0] rdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  lsu_dmem_if #(.TIMEOUT(TIMEOUT), .TW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we        (we),
    .sel       (sel),
    .addr      (addr),
    .wdata     (wdata),
    .stall     (stall),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ack_at: BUS cycle (1-based) in which mem_ack is raised; 0 means never.
  task automatic run_access(input string nm, input logic we_i, input logic [3:0] sel_i,
                            input logic [31:0] addr_i, input logic [31:0] wdata_i,
                            input int ack_at, input logic [31:0] word_i);
    int size, off, exp_lat, exp_req_cycles, n, req_cycles;
    bit ok, seen_done, acked;
    logic exp_err;
    logic [31:0] exp_be, exp_wd, exp_rd, v;

    size = (sel_i == 4'd0) ? 4 : ((sel_i == 4'd1 || sel_i == 4'd2 || sel_i == 4'd5) ? 1 : 2);
    off  = int'(addr_i % 4);
    ok   = (we_i ? (sel_i == 4'd0 || sel_i == 4'd5 || sel_i == 4'd6) : (sel_i <= 4'd4))
           && ((addr_i % size) == 0);
    acked = ok && (ack_at >= 1) && (ack_at <= TIMEOUT);
    exp_err = !acked;
    exp_lat = !ok ? 1 : (acked ? ack_at + 1 : TIMEOUT + 1);
    exp_req_cycles = !ok ? 0 : (acked ? ack_at : TIMEOUT);
    exp_be = we_i ? 32'((((1 << size) - 1) << off) & 15) : 32'h0;
    exp_wd = (size == 1) ? wdata_i[7:0] * 32'h01010101 :
             (size == 2) ? wdata_i[15:0] * 32'h00010001 : wdata_i;
    v = word_i >> (8 * off);
    if (size == 1) begin
      v = v & 32'hFF;
      if (sel_i == 4'd1 && v[7]) v = v | 32'hFFFFFF00;
    end else if (size == 2) begin
      v = v & 32'hFFFF;
      if (sel_i == 4'd3 && v[15]) v = v | 32'hFFFF0000;
    end
    exp_rd = (exp_err || we_i) ? 32'h0 : v;

    req = 1'b1; we = we_i; sel = sel_i; addr = addr_i; wdata = wdata_i;
    #1;
    check({nm, " stall_on_req"}, 32'(stall), 32'd1);
    n = 0; seen_done = 0; req_cycles = 0;
    while (!seen_done && n < 40) begin
      @(posedge clk); #1; n++;
      mem_ack = 1'b0;
      if (done) seen_done = 1;
      else begin
        if (mem_req) req_cycles++;
        check({nm, " stall_busy"}, 32'(stall), 32'd1);
        if (n == 1 && ok) begin
          check({nm, " mem_we"}, 32'(mem_we), 32'(we_i));
          check({nm, " mem_be"}, 32'(mem_be), exp_be);
          check({nm, " mem_addr"}, {2'b00, mem_addr}, addr_i >> 2);
          if (we_i) check({nm, " mem_wdata"}, mem_wdata, exp_wd);
        end
        mem_ack   = (n == ack_at);
        mem_rdata = word_i;
      end
    end
    check({nm, " done_seen"}, 32'(seen_done), 32'd1);
    check({nm, " latency"}, 32'(n), 32'(exp_lat));
    check({nm, " err"}, 32'(err), 32'(exp_err));
    check({nm, " rdata"}, rdata, exp_rd);
    check({nm, " stall_done"}, 32'(stall), 32'd0);
    check({nm, " mem_req_done"}, 32'(mem_req), 32'd0);
    check({nm, " req_cycles"}, 32'(req_cycles), 32'(exp_req_cycles));
    $display("txn %-10s we=%0d sel=%0d addr=%h wdata=%h ack_at=%0d -> lat=%0d err=%0d rdata=%h",
             nm, we_i, sel_i, addr_i, wdata_i, ack_at, n, err, rdata);
    req = 1'b0;
    @(posedge clk); #1;
    check({nm, " done_one_cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; sel = 4'h0; addr = 32'h0; wdata = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst stall", 32'(stall), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst err", 32'(err), 32'd0);
    check("rst rdata", rdata, 32'h0);
    check("rst mem_req", 32'(mem_req), 32'd0);
    check("rst mem_we", 32'(mem_we), 32'd0);
    check("rst mem_be", 32'(mem_be), 32'd0);
    check("rst mem_addr", {2'b00, mem_addr}, 32'h0);
    check("rst mem_wdata", mem_wdata, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_access("lb",      1'b0, 4'd1, 32'h0000_1003, 32'h0,        1, 32'h80FF_1234);
    run_access("lhu",     1'b0, 4'd4, 32'h0000_1002, 32'h0,        1, 32'h9ABC_5678);
    run_access("lh",      1'b0, 4'd3, 32'h0000_1002, 32'h0,        1, 32'h9ABC_5678);
    run_access("lbu",     1'b0, 4'd2, 32'h0000_1001, 32'h0,        2, 32'h80FF_9234);
    run_access("lw",      1'b0, 4'd0, 32'h0000_1004, 32'h0,        3, 32'hDEAD_BEEF);
    run_access("sb",      1'b1, 4'd5, 32'h0000_2001, 32'h0000_00A5, 1, 32'h0);
    run_access("sh",      1'b1, 4'd6, 32'h0000_2002, 32'h0000_1234, 1, 32'h0);
    run_access("sw",      1'b1, 4'd0, 32'h0000_2008, 32'hCAFE_F00D, 2, 32'h0);
    run_access("lw_mis",  1'b0, 4'd0, 32'h0000_3002, 32'h0,        1, 32'h1111_1111);
    run_access("st_ill",  1'b1, 4'd1, 32'h0000_3000, 32'h5,        1, 32'h0);
    run_access("sel_ill", 1'b0, 4'd9, 32'h0000_3000, 32'h0,        1, 32'h0);
    run_access("sh_mis",  1'b1, 4'd6, 32'h0000_3001, 32'h7,        1, 32'h0);
    run_access("sw_tmo",  1'b1, 4'd0, 32'h0000_4000, 32'h1234_5678, 0, 32'h0);
    run_access("sw_last", 1'b1, 4'd0, 32'h0000_4004, 32'h1234_5678, TIMEOUT, 32'h0);
    run_access("lw_late", 1'b0, 4'd0, 32'h0000_4008, 32'h0,        TIMEOUT + 1, 32'h7777_7777);

    // Stray acks while idle must not start or complete anything.
    mem_ack = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check("idle_ack done", 32'(done), 32'd0);
      check("idle_ack mem_req", 32'(mem_req), 32'd0);
    end
    mem_ack = 1'b0;

    // Reset in the second BUS cycle aborts without a done pulse.
    req = 1'b1; we = 1'b1; sel = 4'd0; addr = 32'h0000_0040; wdata = 32'hA5A5_0000;
    repeat (2) begin @(posedge clk); #1; end
    check("pre_rst mem_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst mem_req", 32'(mem_req), 32'd0);
    check("mid_rst stall", 32'(stall), 32'd0);
    check("mid_rst done", 32'(done), 32'd0);
    $display("txn reset_mid_bus mem_req=%0d stall=%0d done=%0d", mem_req, stall, done);
    @(posedge clk); #1;
    req = 1'b0; rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("post_rst done", 32'(done), 32'd0);
    end
    run_access("lw_after", 1'b0, 4'd0, 32'h0000_0080, 32'h0, 1, 32'h0BAD_F00D);

    for (int i = 0; i < 40; i++) begin
      logic        r_we;
      logic [3:0]  r_sel;
      logic [31:0] r_addr, r_wd, r_word;
      int          r_ack;
      r_we   = 1'($urandom_range(0, 1));
      r_sel  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
      r_addr = $urandom;
      r_wd   = $urandom;
      r_word = $urandom;
      r_ack  = $urandom_range(0, TIMEOUT + 1);
      run_access("rand", r_we, r_sel, r_addr, r_wd, r_ack, r_word);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
